// File: rtl/alu_stateful_seg.sv
// rtl/alu_stateful_seg.sv - stateful action ALU with per-tenant segmented memory
// Two-stage action pipeline; the segment table is programmed in-band from the control stream.
module alu_stateful_seg #(
  parameter int STAGE_ID             = 0,
  parameter int ACTION_LEN           = 25,
  parameter int DATA_WIDTH           = 32,
  parameter int MEM_AW               = 5,
  parameter int NUM_TENANTS          = 16,
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [ACTION_LEN-1:0]               action_in,
  input  logic                                action_valid,
  input  logic [DATA_WIDTH-1:0]               operand_1_in,
  input  logic [DATA_WIDTH-1:0]               operand_2_in,
  input  logic [DATA_WIDTH-1:0]               operand_3_in,
  input  logic [11:0]                         vlan_id,
  output logic [DATA_WIDTH-1:0]               container_out,
  output logic                                container_out_valid,
  output logic                                seg_fault,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      c_s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     c_s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    c_s_axis_tkeep,
  input  logic                                c_s_axis_tvalid,
  input  logic                                c_s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]      c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]     c_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]    c_m_axis_tkeep,
  output logic                                c_m_axis_tvalid,
  output logic                                c_m_axis_tlast
);

  localparam int TW = (NUM_TENANTS > 1) ? $clog2(NUM_TENANTS) : 1;
  localparam int LW = MEM_AW + 1;
  localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_STORE = 4'b1000;
  localparam logic [3:0] OP_LOAD  = 4'b1011;
  localparam logic [3:0] OP_LOADD = 4'b0111;
  localparam logic [7:0] CFG_MOD  = {5'(STAGE_ID), 3'd3};

  typedef enum logic [1:0] {C_IDLE, C_DATA, C_SKIP} cstate_e;

  cstate_e         cstate_q, cstate_d;
  logic [7:0]      idx_q, idx_d;
  logic            tbl_we;
  logic [TW-1:0]   tbl_idx;
  logic [MEM_AW-1:0] base_q [NUM_TENANTS];
  logic [MEM_AW-1:0] base_d [NUM_TENANTS];
  logic [LW-1:0]     len_q  [NUM_TENANTS];
  logic [LW-1:0]     len_d  [NUM_TENANTS];

  logic [DATA_WIDTH-1:0] mem_q [2**MEM_AW];

  logic [TW-1:0]         tenant;
  logic [3:0]            op0;
  logic                  fault0;
  logic [MEM_AW-1:0]     pa0;

  logic                  s1_valid_q, s1_valid_d, s1_fault_q, s1_fault_d;
  logic [3:0]            s1_op_q, s1_op_d;
  logic [DATA_WIDTH-1:0] s1_op1_q, s1_op1_d, s1_op2_q, s1_op2_d;
  logic [MEM_AW-1:0]     s1_pa_q, s1_pa_d;
  logic [DATA_WIDTH-1:0] rd1;

  logic                  s2_valid_q, s2_valid_d, s2_we_q, s2_we_d, s2_fault_q, s2_fault_d;
  logic [DATA_WIDTH-1:0] s2_res_q, s2_res_d;
  logic [MEM_AW-1:0]     s2_pa_q, s2_pa_d;

  logic [DATA_WIDTH-1:0] container_out_q, container_out_d;
  logic                  container_out_valid_q, container_out_valid_d;
  logic                  seg_fault_q, seg_fault_d;

  logic [C_S_AXIS_DATA_WIDTH-1:0]  cm_tdata_q, cm_tdata_d;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] cm_tuser_q, cm_tuser_d;
  logic [KW-1:0]                   cm_tkeep_q, cm_tkeep_d;
  logic                            cm_tvalid_q, cm_tvalid_d, cm_tlast_q, cm_tlast_d;

  logic unused_ok;
  assign unused_ok = ^{operand_3_in, action_in[ACTION_LEN-5:0], vlan_id[11:8], vlan_id[3:0]};

  // Control stream: packet-level FSM deciding whether the closing beat programs the table.
  always_comb begin
    cstate_d = cstate_q;
    idx_d    = idx_q;
    tbl_we   = 1'b0;
    case (cstate_q)
      C_IDLE: begin
        if (c_s_axis_tvalid && !c_s_axis_tlast) begin
          if (c_s_axis_tdata[368 +: 8] == CFG_MOD) begin
            cstate_d = C_DATA;
            idx_d    = c_s_axis_tdata[384 +: 8];
          end else begin
            cstate_d = C_SKIP;
          end
        end
      end
      C_DATA: begin
        if (c_s_axis_tvalid && c_s_axis_tlast) begin
          tbl_we   = ({24'd0, idx_q} < NUM_TENANTS);
          cstate_d = C_IDLE;
        end
      end
      C_SKIP: begin
        if (c_s_axis_tvalid && c_s_axis_tlast) cstate_d = C_IDLE;
      end
      default: cstate_d = C_IDLE;
    endcase
  end

  assign tbl_idx = idx_q[TW-1:0];

  always_comb begin
    base_d = base_q;
    len_d  = len_q;
    if (tbl_we) begin
      base_d[tbl_idx] = c_s_axis_tdata[8 +: MEM_AW];
      len_d[tbl_idx]  = c_s_axis_tdata[0 +: LW];
    end
  end

  // Stage 0 resolves tenant segment against the table as it stands before this edge.
  assign tenant = TW'({28'd0, vlan_id[7:4]} % NUM_TENANTS);
  assign op0    = action_in[ACTION_LEN-1 -: 4];
  assign fault0 = (op0 == OP_STORE || op0 == OP_LOAD || op0 == OP_LOADD) &&
                  (operand_2_in >= DATA_WIDTH'(len_q[tenant]));
  assign pa0    = base_q[tenant] + operand_2_in[MEM_AW-1:0];

  always_comb begin
    s1_valid_d = action_valid;
    s1_op_d    = op0;
    s1_op1_d   = operand_1_in;
    s1_op2_d   = operand_2_in;
    s1_pa_d    = pa0;
    s1_fault_d = fault0;
  end

  // The pending stage-2 write commits one edge late, so a same-address read takes it directly.
  assign rd1 = (s2_valid_q && s2_we_q && (s2_pa_q == s1_pa_q)) ? s2_res_q : mem_q[s1_pa_q];

  always_comb begin
    s2_valid_d = s1_valid_q;
    s2_pa_d    = s1_pa_q;
    s2_fault_d = s1_fault_q;
    s2_res_d   = s1_op1_q;
    s2_we_d    = 1'b0;
    if (!s1_fault_q) begin
      case (s1_op_q)
        OP_ADD:   s2_res_d = s1_op1_q + s1_op2_q;
        OP_SUB:   s2_res_d = s1_op1_q - s1_op2_q;
        OP_STORE: s2_we_d  = 1'b1;
        OP_LOAD:  s2_res_d = rd1;
        OP_LOADD: begin
          s2_res_d = rd1 + 1'b1;
          s2_we_d  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    container_out_d       = s2_valid_q ? s2_res_q : container_out_q;
    container_out_valid_d = s2_valid_q;
    seg_fault_d           = s2_valid_q & s2_fault_q;
    cm_tdata_d            = c_s_axis_tdata;
    cm_tuser_d            = c_s_axis_tuser;
    cm_tkeep_d            = c_s_axis_tkeep;
    cm_tvalid_d           = c_s_axis_tvalid;
    cm_tlast_d            = c_s_axis_tlast;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cstate_q <= C_IDLE;
      idx_q    <= '0;
      for (int i = 0; i < NUM_TENANTS; i++) begin
        base_q[i] <= '0;
        len_q[i]  <= '0;
      end
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_op1_q   <= '0;
      s1_op2_q   <= '0;
      s1_pa_q    <= '0;
      s1_fault_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_we_q    <= 1'b0;
      s2_fault_q <= 1'b0;
      s2_res_q   <= '0;
      s2_pa_q    <= '0;
      container_out_q       <= '0;
      container_out_valid_q <= 1'b0;
      seg_fault_q           <= 1'b0;
      cm_tdata_q  <= '0;
      cm_tuser_q  <= '0;
      cm_tkeep_q  <= '0;
      cm_tvalid_q <= 1'b0;
      cm_tlast_q  <= 1'b0;
    end else begin
      cstate_q <= cstate_d;
      idx_q    <= idx_d;
      base_q   <= base_d;
      len_q    <= len_d;
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_op1_q   <= s1_op1_d;
      s1_op2_q   <= s1_op2_d;
      s1_pa_q    <= s1_pa_d;
      s1_fault_q <= s1_fault_d;
      s2_valid_q <= s2_valid_d;
      s2_we_q    <= s2_we_d;
      s2_fault_q <= s2_fault_d;
      s2_res_q   <= s2_res_d;
      s2_pa_q    <= s2_pa_d;
      container_out_q       <= container_out_d;
      container_out_valid_q <= container_out_valid_d;
      seg_fault_q           <= seg_fault_d;
      cm_tdata_q  <= cm_tdata_d;
      cm_tuser_q  <= cm_tuser_d;
      cm_tkeep_q  <= cm_tkeep_d;
      cm_tvalid_q <= cm_tvalid_d;
      cm_tlast_q  <= cm_tlast_d;
    end
  end

  always_ff @(posedge clk) begin
    if (s2_valid_q && s2_we_q) mem_q[s2_pa_q] <= s2_res_q;
  end

  assign container_out       = container_out_q;
  assign container_out_valid = container_out_valid_q;
  assign seg_fault           = seg_fault_q;
  assign c_m_axis_tdata      = cm_tdata_q;
  assign c_m_axis_tuser      = cm_tuser_q;
  assign c_m_axis_tkeep      = cm_tkeep_q;
  assign c_m_axis_tvalid     = cm_tvalid_q;
  assign c_m_axis_tlast      = cm_tlast_q;

endmodule

// File: tb/tb_alu_stateful_seg.sv
// tb/tb_alu_stateful_seg.sv - directed bench for alu_stateful_seg with packet-level reference model
// Actions and control beats change on negedges; outputs are sampled on negedges.
module tb_alu_stateful_seg;
  localparam int CDW = 512;
  localparam int CUW = 128;
  localparam int CKW = 64;
  localparam int BW  = CDW + CUW + CKW + 2;
  localparam logic [3:0] ADD = 4'b0001, SUB = 4'b0010, STORE = 4'b1000,
                         LOAD = 4'b1011, LOADD = 4'b0111, ILL = 4'b0011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [24:0]    action_in = '0;
  logic           action_valid = 1'b0;
  logic [31:0]    operand_1_in = '0, operand_2_in = '0, operand_3_in = '0;
  logic [11:0]    vlan_id = '0;
  logic [31:0]    container_out;
  logic           container_out_valid, seg_fault;
  logic [CDW-1:0] c_s_axis_tdata = '0;
  logic [CUW-1:0] c_s_axis_tuser = '0;
  logic [CKW-1:0] c_s_axis_tkeep = '0;
  logic           c_s_axis_tvalid = 1'b0, c_s_axis_tlast = 1'b0;
  logic [CDW-1:0] c_m_axis_tdata;
  logic [CUW-1:0] c_m_axis_tuser;
  logic [CKW-1:0] c_m_axis_tkeep;
  logic           c_m_axis_tvalid, c_m_axis_tlast;

  alu_stateful_seg dut (
    .clk(clk), .rst_n(rst_n),
    .action_in(action_in), .action_valid(action_valid),
    .operand_1_in(operand_1_in), .operand_2_in(operand_2_in), .operand_3_in(operand_3_in),
    .vlan_id(vlan_id),
    .container_out(container_out), .container_out_valid(container_out_valid), .seg_fault(seg_fault),
    .c_s_axis_tdata(c_s_axis_tdata), .c_s_axis_tuser(c_s_axis_tuser), .c_s_axis_tkeep(c_s_axis_tkeep),
    .c_s_axis_tvalid(c_s_axis_tvalid), .c_s_axis_tlast(c_s_axis_tlast),
    .c_m_axis_tdata(c_m_axis_tdata), .c_m_axis_tuser(c_m_axis_tuser), .c_m_axis_tkeep(c_m_axis_tkeep),
    .c_m_axis_tvalid(c_m_axis_tvalid), .c_m_axis_tlast(c_m_axis_tlast)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: tenant tables, flat memory, and a queue of expected results with due cycle.
  logic [31:0] mm [32];
  logic [4:0]  mbase [16];
  logic [5:0]  mlen [16];
  int          cyc;
  int          pkt_len;
  logic [7:0]  first_mod, first_idx;
  int          q_due[$];
  logic [31:0] q_res[$];
  logic        q_flt[$];
  logic [BW-1:0] prev_bus;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mbase[i] = '0;
      mlen[i]  = '0;
    end
    pkt_len = 0;
    prev_bus = '0;
    q_due.delete();
    q_res.delete();
    q_flt.delete();
  endtask

  task automatic model_action();
    logic [3:0]  op;
    logic [3:0]  t;
    logic [4:0]  pa;
    logic [31:0] res;
    logic        f;
    op  = action_in[24:21];
    t   = vlan_id[7:4];
    res = operand_1_in;
    f   = 1'b0;
    if (op == STORE || op == LOAD || op == LOADD) begin
      if (operand_2_in >= {26'd0, mlen[t]}) begin
        f = 1'b1;
      end else begin
        pa = mbase[t] + operand_2_in[4:0];
        if (op == STORE) mm[pa] = operand_1_in;
        else if (op == LOAD) res = mm[pa];
        else begin
          mm[pa] = mm[pa] + 32'd1;
          res = mm[pa];
        end
      end
    end else if (op == ADD) begin
      res = operand_1_in + operand_2_in;
    end else if (op == SUB) begin
      res = operand_1_in - operand_2_in;
    end
    q_due.push_back(cyc + 2);
    q_res.push_back(res);
    q_flt.push_back(f);
  endtask

  task automatic model_ctrl();
    if (pkt_len == 0) begin
      first_mod = c_s_axis_tdata[375:368];
      first_idx = c_s_axis_tdata[391:384];
    end
    pkt_len++;
    if (c_s_axis_tlast) begin
      if (pkt_len >= 2 && first_mod == 8'h03 && first_idx < 8'd16) begin
        mbase[first_idx[3:0]] = c_s_axis_tdata[12:8];
        mlen[first_idx[3:0]]  = c_s_axis_tdata[5:0];
      end
      pkt_len = 0;
    end
  endtask

  initial begin
    cyc = 0;
    for (int i = 0; i < 32; i++) mm[i] = '0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        cyc++;
        if (action_valid) model_action();
        if (c_s_axis_tvalid) model_ctrl();
        prev_bus = {c_s_axis_tdata, c_s_axis_tuser, c_s_axis_tkeep, c_s_axis_tvalid, c_s_axis_tlast};
      end
    end
  end

  initial begin
    logic [BW-1:0] cm;
    forever begin
      @(negedge clk);
      if (q_due.size() > 0 && q_due[0] == cyc) begin
        check("m_valid", 32'(container_out_valid), 32'd1);
        check("m_data", container_out, q_res[0]);
        check("m_fault", 32'(seg_fault), 32'(q_flt[0]));
        void'(q_due.pop_front());
        void'(q_res.pop_front());
        void'(q_flt.pop_front());
      end else begin
        check("m_idle_valid", 32'(container_out_valid), 32'd0);
        check("m_idle_fault", 32'(seg_fault), 32'd0);
      end
      cm = {c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tvalid, c_m_axis_tlast};
      n_cmp++;
      if (cm !== prev_bus) begin
        n_err++;
        $display("FAIL cm_fwd got=%h exp=%h", cm, prev_bus);
      end
    end
  end

  task automatic act(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [11:0] v);
    action_in    = {op, 21'd0};
    operand_1_in = a;
    operand_2_in = b;
    vlan_id      = v;
    action_valid = 1'b1;
    @(negedge clk);
    action_valid = 1'b0;
  endtask

  task automatic beat(input logic [CDW-1:0] d, input logic last);
    c_s_axis_tdata  = d;
    c_s_axis_tuser  = {4{32'hC0DE_0000 | 32'(d[7:0])}};
    c_s_axis_tkeep  = '1;
    c_s_axis_tvalid = 1'b1;
    c_s_axis_tlast  = last;
    @(negedge clk);
    c_s_axis_tvalid = 1'b0;
    c_s_axis_tlast  = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [31:0] v, input logic f);
    check({nm, "_valid"}, 32'(container_out_valid), 32'd1);
    check(nm, container_out, v);
    check({nm, "_fault"}, 32'(seg_fault), 32'(f));
  endtask

  initial begin
    logic [CDW-1:0] td;
    repeat (3) @(negedge clk);
    check("rst_out", container_out, 32'd0);
    check("rst_valid", 32'(container_out_valid), 32'd0);
    check("rst_fault", 32'(seg_fault), 32'd0);
    check("rst_cm_tvalid", 32'(c_m_axis_tvalid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    act(ADD, 32'd1, 32'd3, 12'h020);   repeat (2) @(negedge clk); expect_out("add", 32'd4, 1'b0);
    act(SUB, 32'd20, 32'd3, 12'h020);  repeat (2) @(negedge clk); expect_out("sub", 32'd17, 1'b0);
    act(SUB, 32'd3, 32'd5, 12'h020);   repeat (2) @(negedge clk); expect_out("sub_wrap", 32'hFFFF_FFFE, 1'b0);
    act(ILL, 32'd20, 32'd7, 12'h020);  repeat (2) @(negedge clk); expect_out("illegal", 32'd20, 1'b0);

    td = '0; td[375:368] = 8'h03; td[391:384] = 8'd4;
    beat(td, 1'b0);
    td = '0; td[15:8] = 8'd8; td[7:0] = 8'd4;
    beat(td, 1'b1);

    act(STORE, 32'd20, 32'd0, 12'h040); repeat (2) @(negedge clk); expect_out("store", 32'd20, 1'b0);
    act(LOAD, 32'd0, 32'd0, 12'h040);   repeat (2) @(negedge clk); expect_out("load", 32'd20, 1'b0);
    act(LOAD, 32'd77, 32'd4, 12'h040);  repeat (2) @(negedge clk); expect_out("load_oob", 32'd77, 1'b1);
    act(LOAD, 32'd9, 32'd0, 12'h050);   repeat (2) @(negedge clk); expect_out("load_unconf", 32'd9, 1'b1);

    act(STORE, 32'd0, 32'd1, 12'h040);
    act(LOADD, 32'd0, 32'd1, 12'h040);
    act(LOADD, 32'd0, 32'd1, 12'h040);
    act(LOADD, 32'd0, 32'd1, 12'h040);
    expect_out("loadd_1", 32'd1, 1'b0);
    @(negedge clk); expect_out("loadd_2", 32'd2, 1'b0);
    @(negedge clk); expect_out("loadd_3", 32'd3, 1'b0);
    @(negedge clk);
    act(LOAD, 32'd0, 32'd0, 12'h040);   repeat (2) @(negedge clk); expect_out("load_keep", 32'd20, 1'b0);

    td = '0; td[375:368] = 8'h05; td[391:384] = 8'd4; td[31:0] = 32'hA5A5_1234;
    c_s_axis_tdata = td; c_s_axis_tkeep = '1; c_s_axis_tvalid = 1'b1; c_s_axis_tlast = 1'b0;
    c_s_axis_tuser = {4{32'h1357_9BDF}};
    @(negedge clk);
    check("fwd_d0", c_m_axis_tdata[31:0], 32'hA5A5_1234);
    check("fwd_mod", 32'(c_m_axis_tdata[375:368]), 32'h05);
    check("fwd_user", c_m_axis_tuser[31:0], 32'h1357_9BDF);
    check("fwd_v0", {30'd0, c_m_axis_tvalid, c_m_axis_tlast}, 32'd2);
    td = '0; td[15:0] = 16'h1000;
    c_s_axis_tdata = td; c_s_axis_tlast = 1'b1;
    @(negedge clk);
    check("fwd_d1", c_m_axis_tdata[31:0], 32'h0000_1000);
    check("fwd_v1", {30'd0, c_m_axis_tvalid, c_m_axis_tlast}, 32'd3);
    c_s_axis_tvalid = 1'b0; c_s_axis_tlast = 1'b0;
    act(LOAD, 32'd0, 32'd0, 12'h040);   repeat (2) @(negedge clk); expect_out("tbl_unchanged", 32'd20, 1'b0);

    td = '0; td[375:368] = 8'h03; td[391:384] = 8'd6;
    c_s_axis_tdata = td; c_s_axis_tvalid = 1'b1; c_s_axis_tlast = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_cm_tvalid", 32'(c_m_axis_tvalid), 32'd0);
    c_s_axis_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    td = '0; td[375:368] = 8'h05; td[15:8] = 8'd0; td[7:0] = 8'd4;
    beat(td, 1'b1);
    act(LOAD, 32'd33, 32'd0, 12'h060);  repeat (2) @(negedge clk); expect_out("fsm_idle_after_rst", 32'd33, 1'b1);
    act(LOAD, 32'd44, 32'd0, 12'h040);  repeat (2) @(negedge clk); expect_out("tbl_cleared", 32'd44, 1'b1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
